// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          FETCH_BUF_DEPTH = 2;
  localparam int          INSN_W          = 32;
  localparam logic [31:0] PC_INC          = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INSN_W-1:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits of a byte address.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr}; slot0 is always the head, empty slots read as zero.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [31:0]       push_pc,
  input  logic [INSN_W-1:0] push_instr,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [31:0]       head_pc,
  output logic [INSN_W-1:0] head_instr,
  output logic              valid
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  fetch_entry_t din;
  logic [1:0]   cnt;
  logic         pop_eff;

  assign din     = '{pc: push_pc, instr: push_instr};
  assign pop_eff = pop && (cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (cnt == 2'd0) begin
            slot0 <= din;
            cnt   <= 2'd1;
          end else if (cnt == 2'd1) begin
            slot1 <= din;
            cnt   <= 2'd2;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: head retires, new entry lands behind the survivor.
          if (cnt == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ        = cnt;
  assign valid      = (cnt != 2'd0);
  assign head_pc    = slot0.pc;
  assign head_instr = slot0.instr;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !pop_eff && cnt == 2'(FETCH_BUF_DEPTH)))
    else $error("fetch_buffer: push into full buffer");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues memory reads and buffers responses for decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
//
// state | meaning
// BOOT  | one idle cycle after reset, no issue
// RUN   | normal issue under the buffer credit rule
// FAULT | misaligned redirect seen (trap build only), no issue until next redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic [31:0] load_pc;
  logic        inflight;
  logic        kill;
  logic        pop;
  logic        push;
  logic        redirect_bad;
  logic [1:0]  occ;
  logic [2:0]  credit_used;
  logic [2:0]  credit_limit;

  // Outstanding work (buffered + in flight) must leave room for the reply.
  assign pop          = if_valid && if_ready;
  assign credit_used  = {1'b0, occ} + {2'b00, inflight};
  assign credit_limit = 3'd2 + {2'b00, pop};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
  assign load_pc      = redirect_pc;
  assign fetch_fault  = (state == FAULT);
`else
  assign redirect_bad = 1'b0;
  assign load_pc      = align_word(redirect_pc);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        mem_rd = !redirect_valid && (credit_used < credit_limit);
      end
      default: begin
        state_nxt = state;
      end
    endcase
    if (redirect_valid) begin
      state_nxt = redirect_bad ? FAULT : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
      kill        <= 1'b0;
    end else begin
      inflight <= mem_rd;
      kill     <= redirect_valid;
      if (mem_rd) begin
        inflight_pc <= pc;
      end
      if (redirect_valid) begin
        pc <= load_pc;
      end else if (mem_rd) begin
        pc <= pc + PC_INC;
      end
    end
  end

  assign push     = inflight && !kill;
  assign mem_addr = {{(32-AW){1'b0}}, pc[AW+1:2]};
  assign mem_wr   = 1'b0;

  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (inflight_pc),
    .push_instr (mem_rdata),
    .pop        (pop),
    .flush      (redirect_valid),
    .occ        (occ),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .valid      (if_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected instruction stream follows the last fetch target.
module tb_fetch_unit;

  localparam int MEM_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  logic [31:0] rom [MEM_DEPTH];
  initial for (int k = 0; k < MEM_DEPTH; k++) rom[k] = 32'h1000_0000 + 32'(k);

  // One-cycle-latency memory; out-of-range addresses return a poison word.
  always @(posedge clk)
    if (mem_rd)
      mem_rdata <= (mem_addr < 32'(MEM_DEPTH)) ? rom[mem_addr[3:0]] : (32'hBAD0_0000 ^ mem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_xfer = 0;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return rom[int'((pc >> 2) % 32'(MEM_DEPTH))];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: next_pc, instr: word_at(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] target);
    exp_q.delete();
    next_pc = target;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every accepted head is popped against the expected stream.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
        n_xfer++;
      end
    end
    if (rst_n && mem_rd) chk("mem_addr_range", mem_addr >> 4, 32'd0);
  end

  logic [31:0] addr_h1, addr_h2, rtgt;
  logic        found;

  initial begin
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    restart(32'd0);
    repeat (3) @(posedge clk);
    sample();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);

    // Reset release: first issue in cycle 2, first head in cycle 4.
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_ready = 1'b1;
    sample(); chk("c1_mem_rd", mem_rd, 0);
    tick(); sample(); chk("c2_mem_rd", mem_rd, 1); chk("c2_mem_addr", mem_addr, 0);
    tick(); sample(); chk("c3_if_valid", if_valid, 0);
    tick(); sample();
    chk("c4_if_valid", if_valid, 1); chk("c4_if_pc", if_pc, 0); chk("c4_if_instr", if_instr, 32'h1000_0000);
    tick(); sample(); chk("c5_if_pc", if_pc, 4); chk("c5_if_valid", if_valid, 1);
    tick(); sample(); chk("c6_if_pc", if_pc, 8); chk("c6_if_valid", if_valid, 1);

    // Backpressure for 6 cycles.
    tick(); if_ready = 1'b0; sample();
    for (int i = 0; i < 5; i++) begin
      tick(); sample();
      chk("stall_if_pc", if_pc, exp_q[0].pc);
    end
    chk("stall_occ", 32'(dut.occ), 2);
    chk("stall_mem_rd", mem_rd, 0);
    chk("stall_if_valid", if_valid, 1);
    tick(); if_ready = 1'b1; sample();

    // Fetch across the end of memory.
    found = 1'b0;
    addr_h1 = 32'hFFFF_FFFF;
    addr_h2 = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(); sample();
      if (if_valid && if_pc == 32'd64) found = 1'b1;
      else begin
        addr_h2 = addr_h1;
        addr_h1 = mem_rd ? mem_addr : 32'hFFFF_FFFF;
      end
    end
    chk("wrap_found", 32'(found), 1);
    chk("wrap_instr", if_instr, 32'h1000_0000);
    chk("wrap_mem_addr", addr_h2, 0);
    tick(); sample(); chk("wrap_pc68", if_pc, 68);
    tick(); sample(); chk("wrap_pc72", if_pc, 72);

    // Redirect with a full buffer.
    tick(); if_ready = 1'b0;
    repeat (4) begin tick(); sample(); end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h20; restart(32'h20); sample();
    tick(); redirect_valid = 1'b0; if_ready = 1'b1; sample();
    chk("rdA_mem_rd", mem_rd, 1); chk("rdA_mem_addr", mem_addr, 8); chk("rdA_flushed", if_valid, 0);
    tick(); sample(); chk("rdA_r2_valid", if_valid, 0);
    tick(); sample();
    chk("rdA_r3_valid", if_valid, 1); chk("rdA_r3_pc", if_pc, 32'h20); chk("rdA_r3_instr", if_instr, 32'h1000_0008);

    // Redirect colliding with a pop and an arriving response.
    repeat (4) begin tick(); sample(); end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h30; restart(32'h30); sample();
    chk("rdB_pop_and_resp", 32'(if_valid && dut.inflight), 1);
    tick(); redirect_valid = 1'b0; sample();
    chk("rdB_occ", 32'(dut.occ), 0); chk("rdB_r1_valid", if_valid, 0);
    tick(); sample(); chk("rdB_r2_valid", if_valid, 0);
    tick(); sample(); chk("rdB_r3_valid", if_valid, 1); chk("rdB_r3_pc", if_pc, 32'h30);

`ifdef FETCH_MISALIGN_TRAP_EN
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h22; restart(32'h20); sample();
    tick(); redirect_valid = 1'b0; sample();
    chk("flt_set", fetch_fault, 1); chk("flt_mem_rd", mem_rd, 0); chk("flt_valid", if_valid, 0);
    repeat (3) begin
      tick(); sample(); chk("flt_hold", fetch_fault, 1); chk("flt_no_issue", mem_rd, 0);
    end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h24; restart(32'h24); sample();
    tick(); redirect_valid = 1'b0; sample();
    chk("flt_clear", fetch_fault, 0); chk("flt_resume_rd", mem_rd, 1); chk("flt_resume_addr", mem_addr, 9);
    tick(); sample();
    tick(); sample();
    chk("flt_resume_valid", if_valid, 1); chk("flt_resume_pc", if_pc, 32'h24);
    chk("flt_resume_instr", if_instr, 32'h1000_0009);
`endif

    // Mid-operation reset.
    repeat (3) begin tick(); sample(); end
    tick(); rst_n = 1'b0; restart(32'd0); sample();
    chk("mr_if_valid", if_valid, 0); chk("mr_mem_rd", mem_rd, 0);
    chk("mr_if_pc", if_pc, 0); chk("mr_mem_addr", mem_addr, 0);
    tick(); rst_n = 1'b1; sample();
    tick(); sample();
    tick(); sample();
    tick(); sample(); chk("mr_c4_valid", if_valid, 1); chk("mr_c4_pc", if_pc, 0);

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 1500; i++) begin
      tick();
      redirect_valid = 1'b0;
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rtgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_00FF);
`ifdef FETCH_MISALIGN_TRAP_EN
        rtgt[1:0] = 2'b00;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = rtgt;
        restart(rtgt & ~32'd3);
      end
      sample();
    end
    tick(); redirect_valid = 1'b0; if_ready = 1'b1;
    repeat (6) begin tick(); sample(); end
    chk("xfer_volume", 32'(n_xfer > 300), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
